vga_sync: RTL and testbench
===========================

Name: vga_sync

Overview:
- Upstream/downstream companion of the pixel renderer. Generates the 640x480@60 raster, feeding col/row to the renderer.
- Takes the renderer's registered 12-bit colour back and drives the VGA connector (hs, vs, 4:4:4 rgb) with sync and blanking aligned to the colour pipeline.
- Also issues a once-per-frame tick at start of vertical blanking for game-state updates.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_VISIBLE, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525
PIX_DIV, 4, clk cycles per pixel; legal 2..16
PIPE, 1, pixel periods from col/row issue to matching rgb_in; legal 1..4

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rgb_in  input  12  colour from renderer {r[11:8], g[7:4], b[3:0]}
col  output  10  horizontal counter, 0..H_TOTAL-1
row  output  10  vertical counter, 0..V_TOTAL-1
visible  output  1  col < H_VISIBLE and row < V_VISIBLE (undelayed)
pix_en  output  1  one-clk strobe per pixel period
frame_tick  output  1  one-clk pulse at entry to vertical blanking
hs  output  1  horizontal sync, active low, pipeline-aligned
vs  output  1  vertical sync, active low, pipeline-aligned
r  output  4  red, zero while blanked
g  output  4  green, zero while blanked
b  output  4  blue, zero while blanked

Behaviour:
- Reset (rst low, asynchronous):
  - Divider, col and row go to 0.
  - Delay lines are loaded with inactive values (de=0, hs=1, vs=1).
  - Outputs: hs=1, vs=1, r=g=b=0, pix_en=0, frame_tick=0.
- After reset release, the first pix_en occurs on the PIX_DIV-th rising clk edge.
- Divider: counts 0..PIX_DIV-1. pix_en is registered high for exactly the one clk cycle in which the divider equals PIX_DIV-1. All raster/pipeline state advances only on cycles where pix_en is high.
- Counters:
  - On pix_en, col increments. At col = H_TOTAL-1, col wraps to 0 and row increments.
  - At row = V_TOTAL-1 with col wrap, row wraps to 0.
  - col/row are registered outputs and hold constant for PIX_DIV clks.
- Raw timing decode from current col/row:
  - de_raw = visible
  - hs_raw low iff H_VISIBLE+H_FRONT <= col < H_VISIBLE+H_FRONT+H_SYNC
  - vs_raw low iff V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC
  - vs is line-granular: changes only when col wraps.
- Alignment:
  - de_raw, hs_raw and vs_raw pass through a PIPE-deep shift register clocked by pix_en.
  - hs/vs are the delay-line outputs, registered, so they lag the counters by exactly PIPE pixel periods.
- Colour:
  - On each pix_en, r/g/b are registered from rgb_in if the delayed de is 1, else to 0.
  - Upstream contract: rgb_in sampled at a pix_en belongs to the col/row issued PIPE pix_en strobes earlier.
  - The renderer's single registered stage meets PIPE=1 because PIX_DIV >= 2.
- frame_tick: high for one clk, coincident with the pix_en on which col wraps H_TOTAL-1 -> 0 and row goes V_VISIBLE-1 -> V_VISIBLE. Exactly one per frame.
- Frame length is exactly H_TOTAL*V_TOTAL*PIX_DIV clks, with no drift. Default: 1,680,000 clks.
- rgb_in changing between pix_en strobes has no effect on outputs.
- Reset asserted mid-line or mid-frame:
  - Immediate return to reset values, with no partial sync pulse completion.
  - After release, raster restarts at (0,0) with blanked colour for the first PIPE pixel periods.

Test Plan:
- Reset then release, PIX_DIV=4 -> first pix_en at the 4th clk edge; col=1 after the first pix_en; hs=vs=1 and rgb=0 throughout reset.
- Run one line -> col wraps after 800 pix_en (3200 clks); hs low for exactly 384 clks, beginning on the pix_en after col becomes 656 (PIPE=1); row goes 0 -> 1.
- Run two frames -> vs low for 2 lines (6400 clks) starting after row becomes 490; frame_tick pulses exactly once per 1,680,000 clks, at the row 479 -> 480 transition.
- Drive rgb_in = 12'hF0A constant -> r=F, g=0, b=A during visible pixels; r=g=b=0 for the 160 blanked pixels per line and the 45 blanked lines.
- PIPE=2, rgb_in = col[3:0] replicated -> output pixel at delayed position N shows N[3:0]; first visible output appears 2 pix_en after col=0.
- Assert rst at col=700, row=491 (inside hsync and vsync) -> hs and vs go to 1 asynchronously; after release, counting resumes from (0,0) with no glitch pulse.

Source files
------------

// File: rtl/vga_sync_if.sv
// Connector-side bundle of the raster generator: raster coordinates out to the
// renderer, colour back in, and the sync/colour lines to the VGA connector.
interface vga_sync_if;
  logic [11:0] rgb_in;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        visible;
  logic        pix_en;
  logic        frame_tick;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;

  modport master (
    input  rgb_in,
    output col, row, visible, pix_en, frame_tick, hs, vs, r, g, b
  );

  modport slave (
    output rgb_in,
    input  col, row, visible, pix_en, frame_tick, hs, vs, r, g, b
  );
endinterface

// File: rtl/vga_sync.sv
// 640x480@60 raster generator: pixel divider, col/row counters, sync decode and
// a PIPE-deep delay line that aligns hs/vs/blanking with the renderer's colour.
module vga_sync #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_DIV   = 4,
  parameter int PIPE      = 1
) (
  input  logic       clk,
  input  logic       rst,
  vga_sync_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_BEG     = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG     = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [3:0] DIV_LAST   = 4'(PIX_DIV - 1);

  logic [3:0]      div_q, div_d;
  logic            pix_en_q, pix_en_d;
  logic [9:0]      col_q, col_d;
  logic [9:0]      row_q, row_d;
  logic            frame_tick_q, frame_tick_d;
  logic            de_raw, hs_raw, vs_raw;
  logic [PIPE-1:0] de_pipe_q, de_pipe_d;
  logic [PIPE-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE-1:0] vs_pipe_q, vs_pipe_d;
  logic [11:0]     rgb_q, rgb_d;

  always_comb begin
    div_d        = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    pix_en_d     = (div_q == DIV_LAST);
    col_d        = col_q;
    row_d        = row_q;
    de_pipe_d    = de_pipe_q;
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    rgb_d        = rgb_q;

    de_raw = (col_q < H_VIS) && (row_q < V_VIS);
    hs_raw = !((col_q >= HS_BEG) && (col_q < HS_END));
    vs_raw = !((row_q >= VS_BEG) && (row_q < VS_END));

    // Registered one cycle ahead so the tick lands on the same clk as the
    // pix_en that moves the raster from the last visible line into blanking.
    frame_tick_d = (div_q == DIV_LAST) && (col_q == H_LAST) && (row_q == V_VIS_LAST);

    if (pix_en_q) begin
      if (col_q == H_LAST) begin
        col_d = 10'd0;
        row_d = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
      de_pipe_d = PIPE'({de_pipe_q, de_raw});
      hs_pipe_d = PIPE'({hs_pipe_q, hs_raw});
      vs_pipe_d = PIPE'({vs_pipe_q, vs_raw});
      // Colour arriving now belongs to the pixel entering the last delay stage.
      rgb_d = de_pipe_d[PIPE-1] ? vga.rgb_in : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= 4'd0;
      pix_en_q     <= 1'b0;
      col_q        <= 10'd0;
      row_q        <= 10'd0;
      frame_tick_q <= 1'b0;
      de_pipe_q    <= '0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      rgb_q        <= 12'h000;
    end else begin
      div_q        <= div_d;
      pix_en_q     <= pix_en_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_tick_q <= frame_tick_d;
      de_pipe_q    <= de_pipe_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      rgb_q        <= rgb_d;
    end
  end

  assign vga.col        = col_q;
  assign vga.row        = row_q;
  assign vga.visible    = de_raw;
  assign vga.pix_en     = pix_en_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.hs         = hs_pipe_q[PIPE-1];
  assign vga.vs         = vs_pipe_q[PIPE-1];
  assign vga.r          = rgb_q[11:8];
  assign vga.g          = rgb_q[7:4];
  assign vga.b          = rgb_q[3:0];
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync on a shrunken raster: every cycle is compared against a
// model that derives the expected outputs from the clk count since reset.
module tb_vga_sync;
  localparam int HV = 20, HF = 3, HSW = 4, HB = 5;
  localparam int VV = 10, VF = 2, VSW = 2, VB = 3;
  localparam int PD = 4, PP = 2;
  localparam int HT = HV + HF + HSW + HB;   // 32
  localparam int VT = VV + VF + VSW + VB;   // 17
  localparam int FR = HT * VT;              // 544 pixels, 2176 clks

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_sync_if vif ();

  vga_sync #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .PIX_DIV(PD), .PIPE(PP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  int          n = 0;          // rising edges since reset release
  logic [11:0] cap = 12'h000;  // rgb_in seen at the most recent sampling edge
  bit          chk_on = 1'b0;
  bit          rgb_mode = 1'b0;

  function automatic bit pe(int k);
    return (k > 0) && ((k % PD) == 0);
  endfunction
  function automatic int adv(int k);
    return (k == 0) ? 0 : (k - 1) / PD;
  endfunction
  function automatic bit de_at(int p);
    int c = p % HT;
    int r = (p / HT) % VT;
    return (c < HV) && (r < VV);
  endfunction
  function automatic bit hs_at(int p);
    int c = p % HT;
    return !((c >= HV + HF) && (c < HV + HF + HSW));
  endfunction
  function automatic bit vs_at(int p);
    int r = (p / HT) % VT;
    return !((r >= VV + VF) && (r < VV + VF + VSW));
  endfunction

  function automatic logic [36:0] model_vec();
    int m = adv(n);
    int t = m % FR;
    int c = t % HT;
    int r = t / HT;
    bit pen = pe(n);
    bit ft = pen && (c == HT - 1) && (r == VV - 1);
    bit hsb = 1'b1, vsb = 1'b1;
    logic [11:0] rgb = 12'h000;
    if (m >= PP) begin
      hsb = hs_at(m - PP);
      vsb = vs_at(m - PP);
      rgb = de_at(m - PP) ? cap : 12'h000;
    end
    return {10'(c), 10'(r), de_at(t), pen, ft, hsb, vsb, rgb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n   <= 0;
      cap <= 12'h000;
    end else begin
      if (pe(n)) cap <= vif.rgb_in;
      n <= n + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on)
      check("raster", {vif.col, vif.row, vif.visible, vif.pix_en, vif.frame_tick,
                       vif.hs, vif.vs, vif.r, vif.g, vif.b}, model_vec());
  end

  // rgb_in changes every clk, so only the strobe-sampled value may matter
  initial begin
    vif.rgb_in = 12'h000;
    forever begin
      @(negedge clk);
      vif.rgb_in = rgb_mode ? 12'hF0A : 12'($urandom);
    end
  end

  initial begin
    int k, w, nf0a, nzero;
    #2 rst = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {vif.hs, vif.vs, vif.r, vif.g, vif.b, vif.pix_en, vif.frame_tick},
          {1'b1, 1'b1, 12'h000, 1'b0, 1'b0});
    rst = 1'b1;

    k = 0;
    do begin @(posedge clk); #1; k++; end while (!vif.pix_en && k < 20);
    check("first_pix_en_edge", k, 4);
    @(posedge clk); #1;
    check("col_after_first_pix_en", vif.col, 1);

    k = 0;
    while (vif.hs !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
    check("hs_seen", k < 1000, 1);
    w = 0;
    while (vif.hs === 1'b0 && w < 1000) begin @(negedge clk); w++; end
    check("hs_low_clks", w, 16);

    k = 0;
    while (vif.frame_tick !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
    check("frame_tick_seen", k < 5000, 1);
    check("frame_tick_pos", {vif.col, vif.row}, {10'd31, 10'd9});
    w = 0;
    do begin @(negedge clk); w++; end while (vif.frame_tick !== 1'b1 && w < 5000);
    check("frame_tick_period", w, 2176);

    k = 0;
    while (vif.vs !== 1'b0 && k < 5000) begin @(negedge clk); k++; end
    check("vs_seen", k < 5000, 1);
    w = 0;
    while (vif.vs === 1'b0 && w < 5000) begin @(negedge clk); w++; end
    check("vs_low_clks", w, 256);

    rgb_mode = 1'b1;
    k = 0;
    while (vif.frame_tick !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
    nf0a = 0; nzero = 0;
    repeat (2176) begin
      @(negedge clk);
      if ({vif.r, vif.g, vif.b} === 12'hF0A) nf0a++;
      if ({vif.r, vif.g, vif.b} === 12'h000) nzero++;
    end
    check("const_colour_clks", nf0a, 800);
    check("blank_colour_clks", nzero, 1376);
    rgb_mode = 1'b0;

    // reset while both sync pulses are low
    k = 0;
    while (!(vif.col == 10'd25 && vif.row == 10'd12) && k < 5000) begin @(negedge clk); k++; end
    check("sync_point_seen", k < 5000, 1);
    check("sync_low_before_reset", {vif.hs, vif.vs}, 2'b00);
    #2 rst = 1'b0;
    #1 check("async_reset_sync", {vif.hs, vif.vs, vif.r, vif.g, vif.b, vif.col, vif.row},
             {1'b1, 1'b1, 12'h000, 10'd0, 10'd0});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(20, 2500)) @(negedge clk);
      #($urandom_range(1, 4));
      rst = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst = 1'b1;
    end
    repeat (3000) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
